// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand bypass selection, long-latency register scoreboard,
// and a flush sequencer that holds redirects/exception flushes until the buses drain.
module hazard_scoreboard #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int REGW    = 5,
    parameter int NFWD    = 3,
    parameter int MAXLONG = 4,
    parameter int CNTW    = $clog2(MAXLONG + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic                   issue_long,
    input  logic [REGW-1:0]        issue_rd,
    input  logic [REGW-1:0]        rs1,
    input  logic [REGW-1:0]        rs2,
    input  logic [XLEN-1:0]        rd1,
    input  logic [XLEN-1:0]        rd2,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic [NFWD*REGW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   long_done,
    input  logic [REGW-1:0]        long_rd,
    input  logic [XLEN-1:0]        long_data,
    input  logic                   redirect,
    input  logic                   exc,
    input  logic                   ibus_busy,
    input  logic                   dbus_busy,
    output logic [XLEN-1:0]        alua,
    output logic [XLEN-1:0]        alub,
    output logic                   stall_fd,
    output logic                   flush_d,
    output logic                   flush_all,
    output logic [CNTW-1:0]        long_cnt
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] REDIR_WAIT = 2'd1;
    localparam logic [1:0] EXC_WAIT   = 2'd2;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXLONG);

    logic [1:0]      state_q, state_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            haz_a, haz_b;
    logic            sb_set;

    // Returns {hazard, operand}; youngest matching bypass shadows older ones.
    function automatic logic [XLEN:0] opsel(input logic [REGW-1:0] s,
                                            input logic [XLEN-1:0] rf);
        logic            found;
        logic [XLEN:0]   res;
        found = 1'b0;
        res   = {1'b0, rf};
        if (s == '0) begin
            res = '0;
        end else begin
            for (int unsigned i = 0; i < NFWD; i++) begin
                if (!found && fwd_valid[i] && fwd_rd[i*REGW +: REGW] == s) begin
                    found = 1'b1;
                    res   = fwd_ready[i] ? {1'b0, fwd_data[i*XLEN +: XLEN]} : {1'b1, rf};
                end
            end
            if (!found) begin
                if (long_done && long_rd == s)
                    res = {1'b0, long_data};
                else if (busy_q[s])
                    res = {1'b1, rf};
            end
        end
        return res;
    endfunction

    always_comb begin
        {haz_a, alua} = opsel(rs1, rd1);
        {haz_b, alub} = opsel(rs2, rd2);
    end

    always_comb begin
        state_d   = state_q;
        flush_d   = 1'b0;
        flush_all = 1'b0;
        case (state_q)
            IDLE, REDIR_WAIT: begin
                if (exc) begin
                    flush_all = 1'b1;
                    state_d   = (ibus_busy || dbus_busy) ? EXC_WAIT : IDLE;
                end else if (state_q == REDIR_WAIT || redirect) begin
                    if (!ibus_busy) begin
                        flush_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = REDIR_WAIT;
                    end
                end
            end
            EXC_WAIT: begin
                flush_all = 1'b1;
                if (!ibus_busy && !dbus_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_fd = haz_a || haz_b || (issue_long && cnt_q == CNT_MAX) || (state_q != IDLE);
    assign sb_set   = issue_valid && issue_long && (issue_rd != '0) && !stall_fd;

    // Set is applied after clear so a same-register set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush_all) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (long_done)
                busy_d[long_rd] = 1'b0;
            if (sb_set)
                busy_d[issue_rd] = 1'b1;
            if (sb_set && !long_done)
                cnt_d = cnt_q + 1'b1;
            else if (!sb_set && long_done && cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign long_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expectations are queued as each
// cycle's stimulus is driven and drained against the outputs mid-cycle.
module tb_hazard_scoreboard;

    localparam int XLEN = 64;
    localparam int REGW = 5;
    localparam int NFWD = 3;
    localparam int CNTW = 3;

    localparam int S_ALUA = 0, S_ALUB = 1, S_STALL = 2, S_FLUSHD = 3, S_FLUSHA = 4, S_CNT = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 issue_valid, issue_long;
    logic [REGW-1:0]      issue_rd, rs1, rs2, long_rd;
    logic [XLEN-1:0]      rd1, rd2, long_data;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [NFWD*REGW-1:0] fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 long_done, redirect, exc, ibus_busy, dbus_busy;
    logic [XLEN-1:0]      alua, alub;
    logic                 stall_fd, flush_d, flush_all;
    logic [CNTW-1:0]      long_cnt;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_scoreboard #(.XLEN(XLEN), .NREG(32), .REGW(REGW), .NFWD(NFWD), .MAXLONG(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .long_done(long_done), .long_rd(long_rd), .long_data(long_data),
        .redirect(redirect), .exc(exc), .ibus_busy(ibus_busy), .dbus_busy(dbus_busy),
        .alua(alua), .alub(alub), .stall_fd(stall_fd), .flush_d(flush_d),
        .flush_all(flush_all), .long_cnt(long_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] sample(input int sig);
        case (sig)
            S_ALUA:   return alua;
            S_ALUB:   return alub;
            S_STALL:  return {63'd0, stall_fd};
            S_FLUSHD: return {63'd0, flush_d};
            S_FLUSHA: return {63'd0, flush_all};
            default:  return {61'd0, long_cnt};
        endcase
    endfunction

    task automatic expect_sig(input string tag, input int sig, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Compare everything queued for this cycle, then advance to just after the next edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, sample(e.sig), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset       = 1'b1;
        issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
        rs1 = 5'd10; rs2 = 5'd11;
        rd1 = 64'h1111; rd2 = 64'h2222;
        fwd_valid = '0; fwd_ready = '1; fwd_rd = '0; fwd_data = '0;
        long_done = 1'b0; long_rd = '0; long_data = '0;
        redirect = 1'b0; exc = 1'b0; ibus_busy = 1'b0; dbus_busy = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        rs1 = 5'd3; rs2 = 5'd4;
        expect_sig("rst_stall", S_STALL, 0);
        expect_sig("rst_flushd", S_FLUSHD, 0);
        expect_sig("rst_flusha", S_FLUSHA, 0);
        expect_sig("rst_alua", S_ALUA, 64'h1111);
        expect_sig("rst_alub", S_ALUB, 64'h2222);
        expect_sig("rst_cnt", S_CNT, 0);
        step();

        // Youngest bypass wins over an older one with the same destination.
        rs1 = 5'd5; fwd_valid = 3'b011;
        fwd_rd[0 +: REGW] = 5'd5; fwd_rd[REGW +: REGW] = 5'd5;
        fwd_data[0 +: XLEN] = 64'hAA; fwd_data[XLEN +: XLEN] = 64'hBB;
        expect_sig("fwd_prio", S_ALUA, 64'hAA);
        expect_sig("fwd_prio_stall", S_STALL, 0);
        step();
        fwd_valid = 3'b010;
        expect_sig("fwd_old", S_ALUA, 64'hBB);
        step();

        idle_inputs();
        rs2 = 5'd7; fwd_valid = 3'b001; fwd_ready = 3'b000;
        fwd_rd[0 +: REGW] = 5'd7; fwd_data[0 +: XLEN] = 64'hDEAD;
        for (int k = 0; k < 2; k++) begin
            expect_sig("lu_stall", S_STALL, 1);
            step();
        end
        fwd_ready = 3'b001;
        expect_sig("lu_alub", S_ALUB, 64'hDEAD);
        expect_sig("lu_go", S_STALL, 0);
        step();

        idle_inputs();
        rs1 = 5'd0; fwd_valid = 3'b001; fwd_rd[0 +: REGW] = 5'd0; fwd_data[0 +: XLEN] = 64'h1234;
        expect_sig("r0_zero", S_ALUA, 0);
        step();

        idle_inputs();
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'(r);
            expect_sig("long_cnt_fill", S_CNT, 64'(r - 1));
            expect_sig("long_stall_fill", S_STALL, 0);
            step();
        end
        issue_rd = 5'd5;
        expect_sig("long_full_cnt", S_CNT, 4);
        expect_sig("long_full_stall", S_STALL, 1);
        step();
        issue_valid = 1'b0; issue_long = 1'b0;
        expect_sig("long_no_5th", S_CNT, 4);
        step();
        long_done = 1'b1; long_rd = 5'd2; long_data = 64'hCAFE; rs1 = 5'd2;
        expect_sig("long_byp", S_ALUA, 64'hCAFE);
        expect_sig("long_byp_stall", S_STALL, 0);
        step();
        long_done = 1'b0;
        expect_sig("long_cnt_dec", S_CNT, 3);
        expect_sig("r2_free_alua", S_ALUA, 64'h1111);
        expect_sig("r2_free_stall", S_STALL, 0);
        step();
        rs2 = 5'd3;
        expect_sig("r3_busy", S_STALL, 1);
        step();

        idle_inputs();
        redirect = 1'b1;
        expect_sig("redir_now", S_FLUSHD, 1);
        expect_sig("redir_now_stall", S_STALL, 0);
        step();
        redirect = 1'b0;
        expect_sig("redir_once", S_FLUSHD, 0);
        step();

        redirect = 1'b1; ibus_busy = 1'b1;
        expect_sig("rw_enter_fd", S_FLUSHD, 0);
        step();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_sig("rw_stall", S_STALL, 1);
            expect_sig("rw_hold_fd", S_FLUSHD, 0);
            step();
        end
        ibus_busy = 1'b0;
        expect_sig("rw_release_fd", S_FLUSHD, 1);
        step();
        expect_sig("rw_done_fd", S_FLUSHD, 0);
        expect_sig("rw_done_stall", S_STALL, 0);
        step();

        // exc beats redirect; a long issue in the flush cycle must not be recorded.
        exc = 1'b1; redirect = 1'b1; dbus_busy = 1'b1;
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        expect_sig("exc_fa0", S_FLUSHA, 1);
        expect_sig("exc_fd0", S_FLUSHD, 0);
        step();
        exc = 1'b0; redirect = 1'b0; issue_valid = 1'b0; issue_long = 1'b0;
        expect_sig("exc_fa1", S_FLUSHA, 1);
        expect_sig("exc_st1", S_STALL, 1);
        expect_sig("exc_fd1", S_FLUSHD, 0);
        step();
        dbus_busy = 1'b0;
        expect_sig("exc_fa2", S_FLUSHA, 1);
        step();
        rs1 = 5'd3; rs2 = 5'd9;
        expect_sig("exc_fa_off", S_FLUSHA, 0);
        expect_sig("exc_cnt0", S_CNT, 0);
        expect_sig("exc_busy_clr", S_STALL, 0);
        expect_sig("exc_alua", S_ALUA, 64'h1111);
        step();

        redirect = 1'b1; ibus_busy = 1'b1;
        step();
        redirect = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        expect_sig("rst_rw_stall", S_STALL, 0);
        expect_sig("rst_rw_fd", S_FLUSHD, 0);
        step();
        ibus_busy = 1'b0;
        exc = 1'b1; dbus_busy = 1'b1;
        step();
        exc = 1'b0; reset = 1'b0;
        expect_sig("ew_hold_fa", S_FLUSHA, 1);
        step();
        reset = 1'b1;
        expect_sig("rst_ew_fa", S_FLUSHA, 0);
        expect_sig("rst_ew_stall", S_STALL, 0);
        step();

        idle_inputs();
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd6;
        step();
        long_done = 1'b1; long_rd = 5'd6;
        expect_sig("sc_pre_cnt", S_CNT, 1);
        step();
        issue_valid = 1'b0; issue_long = 1'b0; long_done = 1'b0; rs1 = 5'd6;
        expect_sig("sc_cnt_same", S_CNT, 1);
        expect_sig("sc_set_wins", S_STALL, 1);
        step();
        long_done = 1'b1; long_rd = 5'd6; rs1 = 5'd10;
        step();
        long_done = 1'b0; rs1 = 5'd6;
        expect_sig("sc_final_cnt", S_CNT, 0);
        expect_sig("sc_final_stall", S_STALL, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the in-order pipeline, replacing the purely combinational flush/stall/forward trio.
- Adds a per-register scoreboard for long-latency (mul/div) ops and a parametrised number of bypass sources.
- Adds a flush sequencer that holds redirects and exception flushes until outstanding bus transactions drain.
- Sits between decode and execute; drives operand muxes, stage stalls and stage flushes.

Parameters:
XLEN, 64, datapath width
NREG, 32, architectural register count (r0 hardwired zero)
REGW, 5, register index width, equals clog2(NREG)
NFWD, 3, bypass sources; index 0 is youngest (EX), higher indices are older
MAXLONG, 4, maximum in-flight long-latency ops

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
issue_valid  in  1  instruction leaving decode this cycle
issue_long  in  1  issued op goes to the long-latency unit
issue_rd  in  REGW  destination of issued op
rs1, rs2  in  REGW  decode source indices
rd1, rd2  in  XLEN  register-file read data
fwd_valid  in  NFWD  bypass source holds a register-writing op
fwd_ready  in  NFWD  bypass source result is available (0 for a load still in EX)
fwd_rd  in  NFWD*REGW  bypass destinations
fwd_data  in  NFWD*XLEN  bypass results
long_done  in  1  long-latency unit writes back this cycle
long_rd  in  REGW  long-latency destination
long_data  in  XLEN  long-latency result
redirect  in  1  branch/jump mispredict resolved in EX
exc  in  1  exception/interrupt taken at commit
ibus_busy, dbus_busy  in  1  bus transactions outstanding
alua, alub  out  XLEN  forwarded operands
stall_fd  out  1  hold fetch and decode
flush_d  out  1  kill the decode-stage instruction
flush_all  out  1  kill F/D/E/M and the long unit
long_cnt  out  clog2(MAXLONG+1)  in-flight long ops

Behaviour:
- Reset (reset==0 at a rising edge): busy[] cleared, long_cnt=0, FSM to IDLE. In the cycle after reset deasserts: stall_fd=0, flush_d=0, flush_all=0, alua=rd1, alub=rd2 (absent a matching bypass).
- Operand select, per source s, highest priority first:
  - s==0 -> 0.
  - First index i with fwd_valid[i] && fwd_rd[i]==s -> fwd_data[i]. If fwd_ready[i]==0 instead -> hazard (load-use).
  - long_done && long_rd==s -> long_data.
  - busy[s] -> hazard.
  - Otherwise rd1/rd2.
- Scoreboard:
  - issue_valid && issue_long && issue_rd!=0 && !stall_fd sets busy[issue_rd] and increments long_cnt.
  - long_done clears busy[long_rd] and decrements long_cnt.
  - Set and clear of the same register in one cycle: set wins. Simultaneous increment and decrement: long_cnt unchanged.
- stall_fd = operand hazard || (issue_long && long_cnt==MAXLONG) || FSM not IDLE.
- Flush FSM states: IDLE, REDIR_WAIT, EXC_WAIT.
  - IDLE + exc: flush_all=1 this cycle; clear busy[] and set long_cnt=0 next edge. Go to EXC_WAIT if ibus_busy||dbus_busy, else stay IDLE.
  - IDLE + redirect (no exc): if !ibus_busy, flush_d=1 for one cycle and stay IDLE; else go to REDIR_WAIT.
  - REDIR_WAIT: stall_fd=1. When !ibus_busy, flush_d=1 that cycle and go to IDLE. exc here takes the IDLE+exc path and drops the redirect.
  - EXC_WAIT: flush_all=1 and stall_fd=1 every cycle. When both buses are idle, go to IDLE. exc and redirect are ignored.
- exc and redirect in the same cycle: exc wins.
- Reset asserted mid-wait: FSM returns to IDLE and all flush outputs drop the next cycle.
- flush_all suppresses scoreboard set for that cycle's issue.

Test Plan:
- rs1=5; fwd_valid=3'b011, fwd_rd[0]=fwd_rd[1]=5, data 0xAA / 0xBB -> alua=0xAA, stall_fd=0.
- Load to r7 in EX (fwd_ready[0]=0), rs2=7 -> stall_fd=1 while not ready; fwd_ready=1 -> alub=load data, stall_fd=0.
- Issue 4 long ops to r1..r4, then a 5th long op -> long_cnt=4, stall_fd=1. Then long_done r2 with rs1=2 -> alua=long_data, long_cnt=3, busy[2]=0.
- rs1=0 with fwd_rd[0]=0 and fwd_data=0x1234 -> alua=0.
- redirect while ibus_busy=1 for 3 cycles -> stall_fd=1 for 3 cycles, then a single flush_d pulse.
- exc with dbus_busy=1 for 2 cycles and redirect in the same cycle -> flush_all=1 for 3 cycles, no flush_d, long_cnt=0 and busy[] empty afterwards.
